// File: rtl/dice_roll_sequencer.sv
`timescale 1ns/1ps
// Fabric-side initiator for the dice-roller RNG custom instruction: issues N rolls, reports sum/min/max.
// Latency: 1 accept cycle + (k+2) cycles per roll + 1 finish cycle; count=0 finishes the cycle after i_go.
// Backpressure: one roll outstanding at a time; each wait for i_done is bounded by TIMEOUT_CYCLES+1 cycles.
module dice_roll_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_go,
  input  logic [3:0]  i_dieSelect,
  input  logic [3:0]  i_count,
  output logic        o_clk_en,
  output logic        o_start,
  output logic [31:0] o_dataa,
  output logic [31:0] o_datab,
  input  logic [31:0] i_result,
  input  logic        i_done,
  output logic        o_busy,
  output logic [8:0]  o_sum,
  output logic [4:0]  o_min,
  output logic [4:0]  o_max,
  output logic [3:0]  o_rolls,
  output logic        o_valid,
  output logic        o_error
);

  // Timeout counter is 16 bits wide so the full 1..65535 range fits.
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Request latched at accept; die code stays on o_dataa for the whole sequence.
  logic [3:0]  die_q;
  logic [3:0]  count_q;

  // Per-roll slave handshake.
  logic [15:0] tmo_q;
  logic [31:0] result_q;

  // Accumulated statistics and registered strobes.
  logic [8:0]  sum_q;
  logic [4:0]  min_q;
  logic [4:0]  max_q;
  logic [3:0]  rolls_q;
  logic        error_q;
  logic        start_q;
  logic        valid_q;
  logic        busy_q;
  logic        clk_en_q;

  // Decoded control from the FSM.
  logic        go_accept;
  logic        accum_ok;
  logic        fault;

  // Derived values of the captured roll.
  logic [4:0]  roll_val;
  logic        result_bad;
  logic [3:0]  rolls_inc;
  logic        last_roll;
  logic        tmo_expired;
  logic [4:0]  min_next;
  logic [4:0]  max_next;

  // Roll value qualification and min/max candidates from the captured result.
  always_comb begin
    roll_val    = result_q[4:0];
    result_bad  = |result_q[31:5];
    rolls_inc   = rolls_q + 4'd1;
    last_roll   = (rolls_inc == count_q);
    tmo_expired = (tmo_q == 16'd0);
    min_next    = (roll_val < min_q) ? roll_val : min_q;
    max_next    = (roll_val > max_q) ? roll_val : max_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    state_d   = state_q;
    go_accept = 1'b0;
    accum_ok  = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_go) begin
          go_accept = 1'b1;
          state_d   = (i_count == 4'd0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving in the last counted cycle still wins over the timeout.
        if (i_done) begin
          state_d = ST_ACCUM;
        end else if (tmo_expired) begin
          fault   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_ACCUM: begin
        if (result_bad) begin
          fault   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          accum_ok = 1'b1;
          state_d  = last_roll ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the request at accept; i_dieSelect/i_count are don't-care afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      die_q   <= 4'd0;
      count_q <= 4'd0;
    end else if (go_accept) begin
      die_q   <= i_dieSelect;
      count_q <= i_count;
    end
  end

  // Timeout counter: loaded on issue, counts down while waiting for done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 16'd0;
    end else if (state_q == ST_ISSUE) begin
      tmo_q <= TMO_LOAD;
    end else if ((state_q == ST_WAIT) && !i_done && !tmo_expired) begin
      tmo_q <= tmo_q - 16'd1;
    end
  end

  // Capture the slave result only on a done seen in WAIT (done during ISSUE is ignored).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'd0;
    end else if ((state_q == ST_WAIT) && i_done) begin
      result_q <= i_result;
    end
  end

  // Statistics: cleared on accept, updated per good roll, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= 9'd0;
      min_q   <= 5'h1F;
      max_q   <= 5'd0;
      rolls_q <= 4'd0;
    end else if (go_accept) begin
      sum_q   <= 9'd0;
      min_q   <= 5'h1F;
      max_q   <= 5'd0;
      rolls_q <= 4'd0;
    end else if (accum_ok) begin
      sum_q   <= sum_q + {4'd0, roll_val};
      min_q   <= min_next;
      max_q   <= max_next;
      rolls_q <= rolls_inc;
    end
  end

  // Error flag: set by timeout or malformed result, cleared only by the next accepted i_go.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (go_accept) begin
      error_q <= 1'b0;
    end else if (fault) begin
      error_q <= 1'b1;
    end
  end

  // Registered strobes aligned with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      start_q  <= (state_d == ST_ISSUE);
      valid_q  <= (state_d == ST_FINISH);
      busy_q   <= (state_d != ST_IDLE);
      clk_en_q <= 1'b1;
    end
  end

  assign o_clk_en = clk_en_q;
  assign o_start  = start_q;
  assign o_dataa  = {28'd0, die_q};
  assign o_datab  = 32'd0;
  assign o_busy   = busy_q;
  assign o_sum    = sum_q;
  assign o_min    = min_q;
  assign o_max    = max_q;
  assign o_rolls  = rolls_q;
  assign o_valid  = valid_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
`timescale 1ns/1ps
// Bench for dice_roll_sequencer: table of roll sequences against a behavioural slave, plus corner cases.
// Latency: expected start/valid cycles derived from the per-roll k+2 timing.
// Backpressure: slave answers each o_start after a programmed k cycles, or never (k=0).
module tb_dice_roll_sequencer;

  logic        clk;
  logic        reset_n;
  logic        i_go;
  logic [3:0]  i_dieSelect;
  logic [3:0]  i_count;
  logic        o_clk_en;
  logic        o_start;
  logic [31:0] o_dataa;
  logic [31:0] o_datab;
  logic [31:0] i_result;
  logic        i_done;
  logic        o_busy;
  logic [8:0]  o_sum;
  logic [4:0]  o_min;
  logic [4:0]  o_max;
  logic [3:0]  o_rolls;
  logic        o_valid;
  logic        o_error;

  dice_roll_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_go        (i_go),
    .i_dieSelect (i_dieSelect),
    .i_count     (i_count),
    .o_clk_en    (o_clk_en),
    .o_start     (o_start),
    .o_dataa     (o_dataa),
    .o_datab     (o_datab),
    .i_result    (i_result),
    .i_done      (i_done),
    .o_busy      (o_busy),
    .o_sum       (o_sum),
    .o_min       (o_min),
    .o_max       (o_max),
    .o_rolls     (o_rolls),
    .o_valid     (o_valid),
    .o_error     (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       die;
    logic [3:0]       count;
    logic [3:0][31:0] res;
    logic [3:0][3:0]  k;
    int               starts;
    int               vcyc;
    int               sum;
    int               mn;
    int               mx;
    int               rolls;
    int               err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave programme: roll j answers res[j%4] after k[j%4] cycles; k=0 never answers.
  logic [3:0][31:0] sl_res;
  logic [3:0][3:0]  sl_k;
  bit               sl_early;

  // Observations from the last run.
  int          start_cyc [16];
  int          n_start;
  int          n_valid;
  int          valid_cyc;
  int          dataa_bad;
  logic [8:0]  v_sum;
  logic [4:0]  v_min;
  logic [4:0]  v_max;
  logic [3:0]  v_rolls;
  logic        v_err;
  logic [8:0]  r_sum;
  logic [4:0]  r_min;
  logic [3:0]  r_rolls;
  logic        r_busy;
  logic        r_clk_en;
  logic [31:0] r_dataa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse i_go at cycle 0, then run max_cyc cycles acting as the RNG slave.
  // Optional extra i_go pulses at g1/g2 and a reset pulse starting at rst_cyc.
  task automatic run_seq(input logic [3:0] die, input logic [3:0] cnt, input int max_cyc,
                         input int g1, input int g2, input int rst_cyc);
    int cd;
    int idx;
    int kk;
    n_start   = 0;
    n_valid   = 0;
    valid_cyc = -1;
    dataa_bad = 0;
    cd        = -1;
    idx       = 0;
    @(negedge clk);
    i_go        = 1'b1;
    i_dieSelect = die;
    i_count     = cnt;
    i_done      = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == rst_cyc + 2) reset_n = 1'b1;
      if (c == rst_cyc) begin
        reset_n = 1'b0;
        #1;
        r_sum    = o_sum;
        r_min    = o_min;
        r_rolls  = o_rolls;
        r_busy   = o_busy;
        r_clk_en = o_clk_en;
        r_dataa  = o_dataa;
        cd       = -1;
      end
      // Inputs are garbage after the accept so the latched request is what counts.
      i_go        = (c == g1) || (c == g2);
      i_dieSelect = ~die;
      i_count     = ~cnt;
      i_done      = 1'b0;
      i_result    = 32'hFFFF_FFE3;
      if (o_busy && ((o_dataa !== {28'd0, die}) || (o_datab !== 32'd0))) dataa_bad++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_done   = 1'b1;
          i_result = sl_res[idx % 4];
          idx++;
          cd = -1;
        end
      end
      if (o_start) begin
        if (n_start < 16) start_cyc[n_start] = c;
        n_start++;
        kk = int'(sl_k[idx % 4]);
        if (kk == 0) begin
          idx++;
          cd = -1;
        end else begin
          cd = kk;
        end
        if (sl_early) begin
          i_done   = 1'b1;
          i_result = 32'h0000_0007;
        end
      end
      if (o_valid) begin
        n_valid++;
        valid_cyc = c;
        v_sum     = o_sum;
        v_min     = o_min;
        v_max     = o_max;
        v_rolls   = o_rolls;
        v_err     = o_error;
      end
    end
    i_go   = 1'b0;
    i_done = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int s;
    vecs[0] = '{die:4'h5, count:4'd3, res:{32'd0, 32'd6, 32'd1, 32'd4}, k:{4'd0, 4'd2, 4'd2, 4'd2},
                starts:3, vcyc:13, sum:11, mn:1, mx:6, rolls:3, err:0};
    vecs[1] = '{die:4'h3, count:4'd0, res:{32'd0, 32'd0, 32'd0, 32'd0}, k:{4'd0, 4'd0, 4'd0, 4'd0},
                starts:0, vcyc:1, sum:0, mn:31, mx:0, rolls:0, err:0};
    vecs[2] = '{die:4'hA, count:4'd1, res:{32'd0, 32'd0, 32'd0, 32'd31}, k:{4'd0, 4'd0, 4'd0, 4'd1},
                starts:1, vcyc:4, sum:31, mn:31, mx:31, rolls:1, err:0};
    vecs[3] = '{die:4'hC, count:4'd2, res:{32'd0, 32'd0, 32'd17, 32'd0}, k:{4'd0, 4'd0, 4'd5, 4'd3},
                starts:2, vcyc:13, sum:17, mn:0, mx:17, rolls:2, err:0};
    vecs[4] = '{die:4'h1, count:4'd3, res:{32'd0, 32'd0, 32'h20, 32'd9}, k:{4'd0, 4'd0, 4'd2, 4'd1},
                starts:2, vcyc:8, sum:9, mn:9, mx:9, rolls:1, err:1};
    vecs[5] = '{die:4'h6, count:4'd2, res:{32'd0, 32'd0, 32'd0, 32'd5}, k:{4'd0, 4'd0, 4'd0, 4'd2},
                starts:2, vcyc:15, sum:5, mn:5, mx:5, rolls:1, err:1};
    vecs[6] = '{die:4'hF, count:4'd15, res:{32'd31, 32'd31, 32'd31, 32'd31}, k:{4'd1, 4'd1, 4'd1, 4'd1},
                starts:15, vcyc:46, sum:465, mn:31, mx:31, rolls:15, err:0};

    reset_n     = 1'b0;
    i_go        = 1'b0;
    i_dieSelect = 4'd0;
    i_count     = 4'd0;
    i_result    = 32'd0;
    i_done      = 1'b0;
    sl_res      = '0;
    sl_k        = '0;
    sl_early    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst clk_en", {31'd0, o_clk_en}, 0);
    chk("rst min", {27'd0, o_min}, 31);
    chk("rst outputs", {o_sum, o_max, o_rolls, o_busy, o_valid, o_start, o_error}, 0);
    chk("rst dataa", o_dataa, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-rst clk_en", {31'd0, o_clk_en}, 1);
    chk("post-rst busy", {31'd0, o_busy}, 0);

    // Table-driven sequences.
    for (int i = 0; i < 7; i++) begin
      sl_res   = vecs[i].res;
      sl_k     = vecs[i].k;
      sl_early = 1'b0;
      run_seq(vecs[i].die, vecs[i].count, vecs[i].vcyc + 3, -1, -1, -100);
      chk($sformatf("v%0d n_start", i), n_start, vecs[i].starts);
      s = 1;
      for (int j = 0; j < vecs[i].starts && j < 16; j++) begin
        chk($sformatf("v%0d start%0d cycle", i, j), start_cyc[j], s);
        s = s + int'(vecs[i].k[j % 4]) + 2;
      end
      chk($sformatf("v%0d n_valid", i), n_valid, 1);
      chk($sformatf("v%0d valid cycle", i), valid_cyc, vecs[i].vcyc);
      chk($sformatf("v%0d sum", i), {23'd0, v_sum}, vecs[i].sum);
      chk($sformatf("v%0d min", i), {27'd0, v_min}, vecs[i].mn);
      chk($sformatf("v%0d max", i), {27'd0, v_max}, vecs[i].mx);
      chk($sformatf("v%0d rolls", i), {28'd0, v_rolls}, vecs[i].rolls);
      chk($sformatf("v%0d error", i), {31'd0, v_err}, vecs[i].err);
      chk($sformatf("v%0d dataa/datab", i), dataa_bad, 0);
      chk($sformatf("v%0d busy after", i), {31'd0, o_busy}, 0);
      chk($sformatf("v%0d sum held", i), {23'd0, o_sum}, vecs[i].sum);
      chk($sformatf("v%0d error held", i), {31'd0, o_error}, vecs[i].err);
    end

    // Early done during the o_start cycle is ignored; real done at k=3 carries 12.
    sl_res   = {32'd0, 32'd0, 32'd0, 32'd12};
    sl_k     = {4'd0, 4'd0, 4'd0, 4'd3};
    sl_early = 1'b1;
    run_seq(4'h2, 4'd1, 9, -1, -1, -100);
    sl_early = 1'b0;
    chk("early n_start", n_start, 1);
    chk("early valid cycle", valid_cyc, 6);
    chk("early sum", {23'd0, v_sum}, 12);
    chk("early min", {27'd0, v_min}, 12);
    chk("early rolls", {28'd0, v_rolls}, 1);

    // i_go while busy and in the FINISH cycle has no effect.
    sl_res = {32'd0, 32'd6, 32'd1, 32'd4};
    sl_k   = {4'd0, 4'd2, 4'd2, 4'd2};
    run_seq(4'h5, 4'd3, 17, 3, 13, -100);
    chk("busy-go n_start", n_start, 3);
    chk("busy-go n_valid", n_valid, 1);
    chk("busy-go valid cycle", valid_cyc, 13);
    chk("busy-go rolls", {28'd0, v_rolls}, 3);
    chk("busy-go sum", {23'd0, v_sum}, 11);
    chk("busy-go dataa", dataa_bad, 0);
    chk("busy-go idle after", {31'd0, o_busy}, 0);

    // Reset mid-WAIT of the second roll: no valid, outputs back to reset values.
    sl_res = {32'd0, 32'd0, 32'd3, 32'd9};
    sl_k   = {4'd0, 4'd0, 4'd6, 4'd1};
    run_seq(4'h4, 4'd2, 16, -1, -1, 6);
    chk("midrst n_start", n_start, 2);
    chk("midrst n_valid", n_valid, 0);
    chk("midrst sum", {23'd0, r_sum}, 0);
    chk("midrst min", {27'd0, r_min}, 31);
    chk("midrst rolls", {28'd0, r_rolls}, 0);
    chk("midrst busy", {31'd0, r_busy}, 0);
    chk("midrst clk_en", {31'd0, r_clk_en}, 0);
    chk("midrst dataa", r_dataa, 0);
    chk("midrst clk_en after", {31'd0, o_clk_en}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
